// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between pipeline writeback (src 0) and multi-cycle results (src 1).
// Latency: accepted at edge N, held in cycle N+1, rf_we in cycle N+2; a lost grant adds one cycle per loss.
// Backpressure: a source's ready drops while its hold register is full and not granted this cycle.
// Optional feature macro: WB_ARB_FAIR_EN (round-robin between sources); undefined gives fixed priority to source 0.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MSB_REG_FILE = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb0_valid,
  input  logic [MSB_REG_FILE-1:0] wb0_addr,
  input  logic [XLEN-1:0]         wb0_data,
  output logic                    wb0_ready,
  input  logic                    wb1_valid,
  input  logic [MSB_REG_FILE-1:0] wb1_addr,
  input  logic [XLEN-1:0]         wb1_data,
  output logic                    wb1_ready,
  output logic                    rf_we,
  output logic [MSB_REG_FILE-1:0] rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  input  logic [MSB_REG_FILE-1:0] hz_rs1_addr,
  input  logic [MSB_REG_FILE-1:0] hz_rs2_addr,
  output logic                    hz_pending
);

  // One-entry hold register per source
  logic                    hold_v0, hold_v1;
  logic [MSB_REG_FILE-1:0] hold_addr0, hold_addr1;
  logic [XLEN-1:0]         hold_data0, hold_data1;

  // age = 1: source 1 holds the older entry; age = 0: source 0 does
  logic age;

`ifdef WB_ARB_FAIR_EN
  // last_grant = 1: source 1 was granted most recently, so source 0 wins next
  logic last_grant;
`endif

  logic grant0, grant1;
  logic acc0, acc1;
  logic cap0, cap1;
  logic same_addr;

  assign same_addr = (hold_addr0 == hold_addr1);

  // Grant selection among valid hold registers only; same-address conflicts resolve by age
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (hold_v0 && hold_v1) begin
      if (same_addr) begin
        grant1 = age;
        grant0 = !age;
      end else begin
`ifdef WB_ARB_FAIR_EN
        grant0 = last_grant;
        grant1 = !last_grant;
`else
        grant0 = 1'b1;
`endif
      end
    end else begin
      grant0 = hold_v0;
      grant1 = hold_v1;
    end
  end

  // A slot can take a new request when empty or when it drains this cycle
  assign wb0_ready = !hold_v0 || grant0;
  assign wb1_ready = !hold_v1 || grant1;
  assign acc0      = wb0_valid && wb0_ready;
  assign acc1      = wb1_valid && wb1_ready;
  // Writes to x0 are acknowledged but never captured
  assign cap0      = acc0 && (wb0_addr != '0);
  assign cap1      = acc1 && (wb1_addr != '0);

  // Source 0 hold register: reload on capture, otherwise clear on grant
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v0    <= 1'b0;
      hold_addr0 <= '0;
      hold_data0 <= '0;
    end else if (cap0) begin
      hold_v0    <= 1'b1;
      hold_addr0 <= wb0_addr;
      hold_data0 <= wb0_data;
    end else if (grant0) begin
      hold_v0    <= 1'b0;
    end
  end

  // Source 1 hold register: reload on capture, otherwise clear on grant
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v1    <= 1'b0;
      hold_addr1 <= '0;
      hold_data1 <= '0;
    end else if (cap1) begin
      hold_v1    <= 1'b1;
      hold_addr1 <= wb1_addr;
      hold_data1 <= wb1_data;
    end else if (grant1) begin
      hold_v1    <= 1'b0;
    end
  end

  // Age tracking: an entry that stays held while the other source captures is the older one
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= 1'b0;
    end else if (cap0 && cap1) begin
      age <= 1'b1;
    end else if (cap1 && hold_v0 && !grant0) begin
      age <= 1'b0;
    end else if (cap0 && hold_v1 && !grant1) begin
      age <= 1'b1;
    end
  end

`ifdef WB_ARB_FAIR_EN
  // Round-robin pointer follows every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end
`endif

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant0 || grant1;
      if (grant0) begin
        rf_waddr <= hold_addr0;
        rf_wdata <= hold_data0;
      end else if (grant1) begin
        rf_waddr <= hold_addr1;
        rf_wdata <= hold_data1;
      end
    end
  end

  // Decode hazard: a nonzero source register matches a result still sitting in a hold register
  always_comb begin
    hz_pending = 1'b0;
    if (hz_rs1_addr != '0) begin
      if ((hold_v0 && (hold_addr0 == hz_rs1_addr)) || (hold_v1 && (hold_addr1 == hz_rs1_addr))) begin
        hz_pending = 1'b1;
      end
    end
    if (hz_rs2_addr != '0) begin
      if ((hold_v0 && (hold_addr0 == hz_rs2_addr)) || (hold_v1 && (hold_addr1 == hz_rs2_addr))) begin
        hz_pending = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a cycle-stamped write scoreboard.
// Expected rf writes are queued when stimulus is driven and matched when rf_we is seen.
// Expectations follow WB_ARB_FAIR_EN when it is defined for the build.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  hz_rs1_addr, hz_rs2_addr;
  logic        hz_pending;

  wb_port_arbiter #(.XLEN(32), .MSB_REG_FILE(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb0_valid  (wb0_valid),
    .wb0_addr   (wb0_addr),
    .wb0_data   (wb0_data),
    .wb0_ready  (wb0_ready),
    .wb1_valid  (wb1_valid),
    .wb1_addr   (wb1_addr),
    .wb1_data   (wb1_data),
    .wb1_ready  (wb1_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .hz_rs1_addr(hz_rs1_addr),
    .hz_rs2_addr(hz_rs2_addr),
    .hz_pending (hz_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Advance one cycle, then match any rf write against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rf_we) begin
      if (sb.size() == 0) begin
        chk("spurious_we", {63'd0, rf_we}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {59'd0, rf_waddr}, {59'd0, e.addr});
        chk("wr_data", {32'd0, rf_wdata}, {32'd0, e.data});
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("missing_we", {63'd0, rf_we}, 64'd1);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    hz_rs1_addr = '0; hz_rs2_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rf_we",    {63'd0, rf_we},      64'd0);
    chk("rst_rf_waddr", {59'd0, rf_waddr},   64'd0);
    chk("rst_rf_wdata", {32'd0, rf_wdata},   64'd0);
    chk("rst_wb0_rdy",  {63'd0, wb0_ready},  64'd1);
    chk("rst_wb1_rdy",  {63'd0, wb1_ready},  64'd1);
    chk("rst_hz",       {63'd0, hz_pending}, 64'd0);

    // Single write: accepted at edge N, visible in cycle N+2
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    #1;
    chk("single_rdy0", {63'd0, wb0_ready}, 64'd1);
    push(5'd5, 32'hDEADBEEF, cyc + 2);
    tick();
    wb0_valid = 1'b0;
    #1;
    chk("single_rdy0_held", {63'd0, wb0_ready}, 64'd1);
    drain(4);

    // x0 write is acknowledged and dropped
    wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h1234;
    hz_rs1_addr = 5'd0;
    #1;
    chk("x0_rdy1", {63'd0, wb1_ready},  64'd1);
    chk("x0_hz",   {63'd0, hz_pending}, 64'd0);
    tick();
    wb1_valid = 1'b0;
    #1;
    chk("x0_hz_after", {63'd0, hz_pending}, 64'd0);
    drain(3);

    // Contention, different addresses; both valid for six cycles
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h33;
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h77;
    base = cyc;
`ifdef WB_ARB_FAIR_EN
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) push(5'd3, 32'h33, base + 2 + k);
      else            push(5'd7, 32'h77, base + 2 + k);
    end
`else
    for (int k = 0; k < 6; k++) push(5'd3, 32'h33, base + 2 + k);
    push(5'd7, 32'h77, base + 8);
`endif
    tick();
    chk("cont_rdy0", {63'd0, wb0_ready}, 64'd1);
    chk("cont_rdy1", {63'd0, wb1_ready}, 64'd0);
    repeat (5) tick();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    drain(4);

    // Same address, same cycle: source 1 is older and writes first
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'hA;
    wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'hB;
    push(5'd9, 32'hB, cyc + 2);
    push(5'd9, 32'hA, cyc + 3);
    tick();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    drain(4);

    // Hazard on a held result, cleared once the write reaches rf_we
    wb1_valid = 1'b1; wb1_addr = 5'd12; wb1_data = 32'hC0FFEE;
    hz_rs2_addr = 5'd12;
    #1;
    chk("hz_before", {63'd0, hz_pending}, 64'd0);
    push(5'd12, 32'hC0FFEE, cyc + 2);
    tick();
    wb1_valid = 1'b0;
    #1;
    chk("hz_held", {63'd0, hz_pending}, 64'd1);
    tick();
    chk("hz_written", {63'd0, hz_pending}, 64'd0);
    drain(2);
    hz_rs2_addr = 5'd0;

    // Reset with both holds full; a request during reset is not accepted
    wb0_valid = 1'b1; wb0_addr = 5'd4; wb0_data = 32'h44;
    wb1_valid = 1'b1; wb1_addr = 5'd6; wb1_data = 32'h66;
    tick();
    wb1_valid = 1'b0;
    hz_rs1_addr = 5'd4; hz_rs2_addr = 5'd6;
    #1;
    chk("mid_hz_held", {63'd0, hz_pending}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb0_valid = 1'b0;
    #1;
    chk("mid_rf_we",    {63'd0, rf_we},      64'd0);
    chk("mid_rf_waddr", {59'd0, rf_waddr},   64'd0);
    chk("mid_rdy0",     {63'd0, wb0_ready},  64'd1);
    chk("mid_rdy1",     {63'd0, wb1_ready},  64'd1);
    chk("mid_hz",       {63'd0, hz_pending}, 64'd0);
    drain(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the pipeline writeback path (Ps6) and the multi-cycle result path (mul/div, load return). Each source has a valid/ready handshake and a one-entry hold register. Grants alternate round-robin, with age ordering applied when both sources target the same destination. The block also reports which decode source registers still have an unwritten pending result, so decode can stall on them.

## Interface
- XLEN, 32, data width.
- MSB_REG_FILE, 5, register address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- wb0_valid  in  1  pipeline writeback request.
- wb0_addr  in  MSB_REG_FILE  destination register.
- wb0_data  in  XLEN  write data.
- wb0_ready  out  1  source 0 may present a new request.
- wb1_valid / wb1_addr / wb1_data / wb1_ready  same as source 0, for the multi-cycle result path.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  MSB_REG_FILE  register file write address (registered).
- rf_wdata  out  XLEN  register file write data (registered).
- hz_rs1_addr, hz_rs2_addr  in  MSB_REG_FILE  decode source addresses.
- hz_pending  out  1  a source register matches a held, unwritten result.

## Operation
- **Hold register per source i:** holds hold_v, hold_addr, hold_data.
  - Accept: wbi_valid && wbi_ready.
  - wbi_ready = !hold_v_i || grant_i. This is combinational, so an uncontested source sustains one request per cycle.
- **Address 0:** an accepted request with address 0 is acknowledged and discarded. It never enters the hold register and never produces rf_we.
- **Candidates:** the arbiter considers only hold registers with hold_v = 1. Inputs are never granted in the cycle they arrive.
- **One candidate:** it is granted.
- **Two candidates, different addresses:** round-robin. The source not granted most recently wins. last_grant updates on every grant.
- **Two candidates, same address:** the older entry wins, regardless of last_grant.
  - Age is one bit, set when the first of two concurrently held entries was captured.
  - If both were captured in the same cycle, source 1 is older.
- **On grant:**
  - rf_we <= 1, rf_waddr <= hold_addr, rf_wdata <= hold_data.
  - hold_v clears unless the same source is accepting a new request in that cycle, in which case the hold register reloads.
- **No grant:** rf_we <= 0; rf_waddr and rf_wdata hold their previous values.
- **hz_pending (combinational):** asserted when, for either hz_rs1_addr or hz_rs2_addr, the address is nonzero and equals hold_addr of any valid hold register.
  - Entries already in the rf_we stage are excluded; the register file bypasses its own in-progress write.
- **Reset:** clears hold_v for both sources, the age bit, last_grant (= 1, so source 0 wins first), rf_we, rf_waddr and rf_wdata. In-flight held writes are lost.

## Timing
- **Reset values:** rf_we = 0, rf_waddr = 0, rf_wdata = 0, wb0_ready = 1, wb1_ready = 1, hz_pending = 0.
- **Latency, uncontested:** request accepted at edge N → held during cycle N+1 → rf_we high during cycle N+2.
- **Latency, contested:** the loser waits one additional cycle per lost grant. Its ready stays low, so the source must hold valid, addr and data stable until accepted.
- **Throughput:** at most one rf write per cycle. Sustained two-source load gives each source one write every two cycles.
- **rst during a handshake:** the request is not accepted. Ready reads 1 in the first cycle after reset is released.

## Configuration
- **WB_ARB_FAIR_EN defined:** round-robin behaviour as above.
- **WB_ARB_FAIR_EN undefined:** fixed priority. Source 0 wins whenever both are held, except for the same-address age rule, which always applies. last_grant is removed.

## Test plan
- **Single write:** wb0 valid, addr 5, data 0xDEADBEEF, at edge N → rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF in cycle N+2; wb0_ready stays 1.
- **x0 drop:** wb1 valid, addr 0, data 0x1234 → accepted (wb1_ready = 1); rf_we stays 0; hz_pending = 0 with hz_rs1_addr = 0.
- **Contention, different addresses:** both valid every cycle after reset, addr 3 and addr 7.
  - With WB_ARB_FAIR_EN: writes alternate 3, 7, 3, 7.
  - Without it: rf_waddr = 3 on every write until wb0 drops valid.
- **Same-address ordering:** both accepted in the same cycle with addr 9 (wb0 data 0xA, wb1 data 0xB) → rf writes 0xB then 0xA on consecutive cycles, so the final value is 0xA.
- **Hazard:** wb1 held with addr 12 and hz_rs2_addr = 12 → hz_pending = 1. It drops to 0 in the cycle rf_we is asserted for addr 12.
- **Reset mid-operation:** both holds valid, then rst pulsed for one cycle → no rf_we in the following cycle; both ready = 1; hz_pending = 0.
